// File: rtl/prism_rx_fifo_pkg.sv
// Shared constants for the PRISM receive FIFO: default bus offsets and
// control/status register bit positions.
package prism_rx_fifo_pkg;

    localparam logic [5:0] ADDR_DATA_DEF = 6'h30;
    localparam logic [5:0] ADDR_CTRL_DEF = 6'h34;

    localparam int LEVEL_LSB  = 0;
    localparam int EMPTY      = 8;
    localparam int FULL       = 9;
    localparam int OVF        = 10;
    localparam int THR_LSB    = 16;
    localparam int IRQ_EN     = 24;
    localparam int OVF_IRQ_EN = 25;
    localparam int OVF_CLR    = 30;
    localparam int FLUSH      = 31;

    localparam logic [1:0] BUS_IDLE = 2'b11;
    localparam logic [1:0] WR_32    = 2'b10;

endpackage

// File: rtl/prism_rx_fifo_mem.sv
// Byte storage for the receive FIFO: pointers, occupancy level and full/empty.
// Callers qualify push/pop; flush takes priority over both.
module prism_rx_fifo_mem #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_ok_i,
    input  logic                     pop_ok_i,
    input  logic                     flush_i,
    input  logic [7:0]               wdata_i,
    output logic [7:0]               head_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [$clog2(DEPTH):0]   level_next_o,
    output logic                     empty_o,
    output logic                     full_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok_i) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok_i)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_ok_i, pop_ok_i})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign head_o       = mem_q[rd_ptr_q];
    assign level_o      = level_q;
    assign level_next_o = level_d;
    assign empty_o      = (level_q == '0);
    assign full_o       = (level_q == LW'(DEPTH));

endmodule

// File: rtl/prism_rx_fifo.sv
// PRISM receive FIFO: captures pushed bytes and exposes a pop-on-read data
// register plus a control/status register, with threshold/overflow interrupt.
module prism_rx_fifo
    import prism_rx_fifo_pkg::*;
#(
    parameter int         DEPTH     = 8,
    parameter logic [5:0] ADDR_DATA = ADDR_DATA_DEF,
    parameter logic [5:0] ADDR_CTRL = ADDR_CTRL_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic [7:0]  push_data,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        not_empty,
    output logic        fifo_irq
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [7:0]    head;
    logic [LW-1:0] level, level_next;
    logic          empty, full;
    logic          rd_active, pop_req, ctrl_wr, flush_w;
    logic          push_ok, pop_ok, ovf_set;
    logic          rd_hist_q;
    logic          ovf_q, ovf_d;
    logic [3:0]    thr_q, thr_d;
    logic          irq_en_q, irq_en_d;
    logic          ovf_irq_en_q, ovf_irq_en_d;
    logic          not_empty_q, irq_q, irq_d;
    logic          unused_data_in;

    // Only the leading edge of a read pops, so a held read drains one byte.
    assign rd_active = (data_read_n != BUS_IDLE);
    assign pop_req   = rd_active && !rd_hist_q && (address == ADDR_DATA);
    assign ctrl_wr   = (data_write_n == WR_32) && (address == ADDR_CTRL);
    assign flush_w   = ctrl_wr && data_in[FLUSH];
    assign pop_ok    = pop_req && !empty && !flush_w;
    assign push_ok   = push && (!full || pop_ok) && !flush_w;
    assign ovf_set   = push && full && !pop_ok && !flush_w;

    prism_rx_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_ok_i    (push_ok),
        .pop_ok_i     (pop_ok),
        .flush_i      (flush_w),
        .wdata_i      (push_data),
        .head_o       (head),
        .level_o      (level),
        .level_next_o (level_next),
        .empty_o      (empty),
        .full_o       (full)
    );

    always_comb begin
        ovf_d        = ovf_q;
        thr_d        = thr_q;
        irq_en_d     = irq_en_q;
        ovf_irq_en_d = ovf_irq_en_q;
        if (ctrl_wr) begin
            thr_d        = data_in[THR_LSB +: 4];
            irq_en_d     = data_in[IRQ_EN];
            ovf_irq_en_d = data_in[OVF_IRQ_EN];
            if (data_in[OVF_CLR]) ovf_d = 1'b0;
        end
        if (ovf_set) ovf_d = 1'b1;
        irq_d = (irq_en_q && (thr_q != 4'd0) && (32'(level_next) >= 32'(thr_q)))
              || (ovf_irq_en_q && ovf_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_hist_q    <= 1'b0;
            ovf_q        <= 1'b0;
            thr_q        <= '0;
            irq_en_q     <= 1'b0;
            ovf_irq_en_q <= 1'b0;
            not_empty_q  <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            rd_hist_q    <= rd_active;
            ovf_q        <= ovf_d;
            thr_q        <= thr_d;
            irq_en_q     <= irq_en_d;
            ovf_irq_en_q <= ovf_irq_en_d;
            not_empty_q  <= (level_next != '0);
            irq_q        <= irq_d;
        end
    end

    always_comb begin
        data_out = '0;
        if (address == ADDR_DATA) begin
            if (!empty) data_out = {23'h0, 1'b1, head};
        end else if (address == ADDR_CTRL) begin
            data_out[LEVEL_LSB +: 5] = 5'(level);
            data_out[EMPTY]          = empty;
            data_out[FULL]           = full;
            data_out[OVF]            = ovf_q;
            data_out[THR_LSB +: 4]   = thr_q;
            data_out[IRQ_EN]         = irq_en_q;
            data_out[OVF_IRQ_EN]     = ovf_irq_en_q;
        end
    end

    assign unused_data_in = ^{data_in[15:0], data_in[23:20], data_in[29:26]};

    assign data_ready = 1'b1;
    assign not_empty  = not_empty_q;
    assign fifo_irq   = irq_q;

endmodule

// File: doc/prism_rx_fifo.md
Name: prism_rx_fifo

Overview:
- Downstream byte-capture stage for the PRISM peripheral.
- Each time PRISM completes a comm_data shift (8-bit mode), the wrapper issues a one-cycle push strobe carrying the byte. This block buffers those bytes in a small FIFO.
- The TinyQV core drains the FIFO through two peripheral-bus registers.
- Outputs: a threshold/overflow interrupt, plus a not-empty flag that the wrapper can route back to a PRISM input bit.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..16.
- ADDR_DATA, 6'h30, bus offset of the data/pop register.
- ADDR_CTRL, 6'h34, bus offset of the control/status register.

Ports:
- clk  input  1  project clock (64 MHz nominal).
- rst_n  input  1  asynchronous active-low reset.
- push  input  1  one-cycle strobe: push_data is a completed byte.
- push_data  input  8  byte to enqueue.
- address  input  6  bus address within the peripheral.
- data_in  input  32  bus write data.
- data_write_n  input  2  11 = idle, 00/01/10 = 8/16/32-bit write.
- data_read_n  input  2  11 = idle, otherwise a read.
- data_out  output  32  read data; valid when address hits ADDR_DATA or ADDR_CTRL, otherwise 0.
- data_ready  output  1  tied 1; all reads complete in one cycle.
- not_empty  output  1  level != 0, registered.
- fifo_irq  output  1  interrupt request, registered.

Behaviour:
- Reset (async, rst_n low):
  - rd_ptr, wr_ptr and level all 0.
  - overflow = 0, threshold = 0, irq_en = 0, ovf_irq_en = 0.
  - not_empty = 0, fifo_irq = 0, read-strobe history = 0.
  - Storage contents are don't-care.
  - Reset mid-operation discards all entries.
- Widths:
  - Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - level is log2(DEPTH)+1 bits and saturates at DEPTH by construction.
- Push: on a push cycle with level < DEPTH, write mem[wr_ptr], increment wr_ptr and level. The byte is readable at ADDR_DATA on the following cycle.
- Pop: occurs only on the first cycle of a read to ADDR_DATA.
  - A read is active when data_read_n != 11.
  - "First cycle" means read active this cycle and inactive last cycle, using a registered history bit.
  - A held read pops once.
  - If level != 0, increment rd_ptr and decrement level.
- ADDR_DATA read value: {23'h0, valid, mem[rd_ptr]}, with valid = (level != 0). When empty, the value is 0x000 and there is no pointer or level change.
- Reads of other addresses never pop.
- Same-cycle push and pop:
  - Not empty (including full): both occur; level is unchanged; wr_ptr and rd_ptr both advance.
  - Empty: the push occurs; the pop reads invalid (valid=0) and is ignored.
- Full with push and no pop: the byte is dropped, pointers are unchanged, and overflow is set (sticky).
- ADDR_CTRL read value:
  - [4:0] level, zero-extended.
  - [8] empty; [9] full; [10] overflow.
  - [19:16] threshold.
  - [24] irq_en; [25] ovf_irq_en.
  - All other bits 0.
- ADDR_CTRL write (32-bit writes only; other widths are ignored), fields taken from data_in:
  - [19:16] threshold, [24] irq_en, [25] ovf_irq_en.
  - [30] = 1 clears overflow.
  - [31] = 1 flushes: pointers and level to 0.
  - Priority is flush > push, so a push in the flush cycle is discarded.
  - Overflow set wins over a same-cycle clear.
- Writes to ADDR_DATA are ignored.
- fifo_irq (next cycle) = (irq_en & threshold != 0 & level_next >= threshold) | (ovf_irq_en & overflow_next).
  - Threshold values greater than DEPTH never fire.
- not_empty (next cycle) = level_next != 0.

Decomposition:
- Package prism_rx_fifo_pkg: ADDR_DATA/ADDR_CTRL defaults and CTRL bit-position constants.
  - Status positions: LEVEL_LSB = 0, EMPTY = 8, FULL = 9, OVF = 10.
  - Field positions: THR_LSB = 16, IRQ_EN = 24, OVF_IRQ_EN = 25, OVF_CLR = 30, FLUSH = 31.
- One sub-module, prism_rx_fifo_mem: DEPTH x 8 storage, pointers, level, and full/empty. Its inputs are push_ok, pop_ok and flush; its output is the head byte.
- Bus decode, overflow and interrupt logic live in the top.

Test Plan:
- Push 0xA5, 0x3C on consecutive cycles, then read ADDR_DATA twice (each a one-cycle strobe) -> 0x1A5 then 0x13C; a third read -> 0x000; level 0 and not_empty 0 afterwards.
- Push 9 bytes 0x01..0x09 with DEPTH=8 -> CTRL reads level 8, full 1, overflow 1. Draining returns 0x01..0x08; 0x09 is absent. Write CTRL bit30 -> overflow 0.
- Hold data_read_n = 10 for 4 cycles at ADDR_DATA while the FIFO holds 0x11, 0x22 -> exactly one pop; the next strobe returns 0x122.
- FIFO full plus a same-cycle push of 0x77 and a pop -> level stays 8, no overflow; 0x77 emerges as the eighth read from that point.
- Threshold = 3 with irq_en = 1, then push 3 bytes -> fifo_irq rises the cycle after the third push; one pop drops it the next cycle. With ovf_irq_en = 1, overflow asserts fifo_irq.
- Flush write coincident with push of 0x55 -> level 0, empty 1. Asserting rst_n low mid-stream with 4 entries -> all outputs 0 immediately; reads afterwards return 0x000.
